// File: rtl/gearbox_rr_arbiter_fc.sv
// Round-robin arbiter feeding one 2-to-1 gearbox through a single-entry output register.
// Define GEARBOX_RR_ARBITER_LOCK_EN to enable burst lock on req_last.
module gearbox_rr_arbiter_fc #(
    parameter int width = 8,
    parameter int n_req = 4,
    localparam int id_w = $clog2(n_req)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [n_req-1:0]           req_valid,
    output logic [n_req-1:0]           req_ready,
    input  logic [n_req*2*width-1:0]   req_data,
    input  logic [n_req-1:0]           req_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*width-1:0]         out_data,
    output logic [id_w-1:0]            out_id
);

    logic                 full;
    logic [2*width-1:0]   data_q;
    logic [id_w-1:0]      id_q;
    logic [id_w-1:0]      last_grant;

    logic [n_req-1:0]     eligible;
    logic                 found;
    logic [id_w-1:0]      winner;
    logic [id_w-1:0]      scan_idx;
    logic                 slot_free;
    logic                 accept;

`ifdef GEARBOX_RR_ARBITER_LOCK_EN
    logic                 locked;
    logic [id_w-1:0]      lock_id;

    // While a burst is open only its owner may compete, even if it is idle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < n_req; i++) begin
            eligible[i] = req_valid[i] & (~locked | (lock_id == id_w'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (accept) begin
            if (!req_last[winner]) begin
                locked  <= 1'b1;
                lock_id <= winner;
            end else begin
                locked  <= 1'b0;
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;

    always_comb begin
        eligible = req_valid;
    end
`endif

    assign slot_free = ~full | (out_valid & out_ready);

    // Scan starts just after the previous winner so the most recent grant has lowest priority.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 1; k <= n_req; k++) begin
            scan_idx = id_w'((int'(last_grant) + k) % n_req);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign accept = found & slot_free;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
            last_grant <= id_w'(n_req - 1);
        end else if (accept) begin
            full       <= 1'b1;
            data_q     <= req_data[int'(winner)*2*width +: 2*width];
            id_q       <= winner;
            last_grant <= winner;
        end else if (out_ready) begin
            full       <= 1'b0;
        end
    end

    assign out_valid = full;
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_gearbox_rr_arbiter_fc.sv
// Self-checking bench for gearbox_rr_arbiter_fc: directed scenarios plus random traffic
// against a behavioural model (follows GEARBOX_RR_ARBITER_LOCK_EN like the RTL).
module tb_gearbox_rr_arbiter_fc;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int DW = 2 * W;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_id;

    int checks = 0;
    int errors = 0;

    bit          m_full;
    logic [15:0] m_data;
    int          m_id;
    int          m_ptr;
    bit          m_locked;
    int          m_lock_id;

    always #5 clk = ~clk;

    gearbox_rr_arbiter_fc #(.width(W), .n_req(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    // A requester may only drop valid after its token was taken.
    logic [N-1:0] pend;
    always @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && !req_valid[i]) $error("[TB] protocol violation: req_valid[%0d] dropped", i);
            end
            pend <= req_valid & ~req_ready;
        end
    end

    function automatic int m_winner();
        logic [N-1:0] elig;
        elig = req_valid;
`ifdef GEARBOX_RR_ARBITER_LOCK_EN
        if (m_locked) elig = req_valid & (4'b0001 << m_lock_id);
`endif
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        w = m_winner();
        if (w >= 0 && (!m_full || out_ready)) return 4'b0001 << w;
        return 4'b0000;
    endfunction

    task automatic m_clock();
        int w;
        if (rst) begin
            m_full = 0; m_data = '0; m_id = 0; m_ptr = N - 1; m_locked = 0; m_lock_id = 0;
        end else begin
            w = m_winner();
            if (w >= 0 && (!m_full || out_ready)) begin
                m_full = 1;
                m_data = req_data[w*DW +: DW];
                m_id   = w;
                m_ptr  = w;
`ifdef GEARBOX_RR_ARBITER_LOCK_EN
                if (!req_last[w]) begin
                    m_locked  = 1;
                    m_lock_id = w;
                end else begin
                    m_locked  = 0;
                end
`endif
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h exp 0000", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_id got %0d exp 0", out_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 0000", req_ready); end
        req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_prio got %b exp 0001", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [15:0] tok [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tok[i];
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << order[c])) begin errors++; $display("[TB] FAIL rr_grant c%0d got %b exp %b", c, req_ready, 4'b0001 << order[c]); end
            if (c > 0) begin
                checks++; if (out_valid !== 1'b1 || out_id !== 2'(order[c-1])) begin errors++; $display("[TB] FAIL rr_out_id c%0d got v%b id%0d exp v1 id%0d", c, out_valid, out_id, order[c-1]); end
                checks++; if (out_data !== tok[order[c-1]]) begin errors++; $display("[TB] FAIL rr_out_data c%0d got %h exp %h", c, out_data, tok[order[c-1]]); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0100; req_last = 4'b1111; req_data[2*DW +: DW] = 16'hC2C2; out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL stall_first_ready got %b exp 0100", req_ready); end
        tick();
        req_data[2*DW +: DW] = 16'h5A5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 16'hC2C2 || out_id !== 2'd2) begin errors++; $display("[TB] FAIL stall_hold c%0d got v%b %h id%0d exp v1 c2c2 id2", c, out_valid, out_data, out_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL stall_ready c%0d got %b exp 0000", c, req_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL stall_drain_accept got %b exp 0100", req_ready); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin errors++; $display("[TB] FAIL stall_overwrite got v%b %h exp v1 5a5a", out_valid, out_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_last = 4'b1111; out_ready = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first got %b exp 1000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_second got %b exp 0010", req_ready); end
        checks++; if (out_id !== 2'd3) begin errors++; $display("[TB] FAIL wrap_id3 got %0d exp 3", out_id); end
        tick();
        #1;
        checks++; if (out_id !== 2'd1) begin errors++; $display("[TB] FAIL wrap_id1 got %0d exp 1", out_id); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100; req_last = 4'b1111; req_data[2*DW +: DW] = 16'h7777; out_ready = 1'b0;
        tick();
        rst = 1'b1; req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_clear got v%b rdy%b exp v0 rdy0000", out_valid, req_ready); end
        req_valid = 4'b0101; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_first_grant got %b exp 0001", req_ready); end
        tick();
    endtask

    task automatic test_lock_burst();
        logic [15:0] tok1 [3] = '{16'h1111, 16'h2222, 16'h3333};
`ifdef GEARBOX_RR_ARBITER_LOCK_EN
        int exp_id [5] = '{1, 1, 1, 0, 0};
`else
        int exp_id [5] = '{1, 0, 1, 0, 1};
`endif
        int t1;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001; req_last = 4'b0001; req_data[0 +: DW] = 16'hAAAA;
        tick();
        t1 = 0;
        req_valid = 4'b0011; req_data[DW +: DW] = tok1[0];
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << exp_id[c])) begin errors++; $display("[TB] FAIL burst_grant c%0d got %b exp %b", c, req_ready, 4'b0001 << exp_id[c]); end
            if (c > 0) begin
                checks++; if (out_id !== 2'(exp_id[c-1])) begin errors++; $display("[TB] FAIL burst_out_id c%0d got %0d exp %0d", c, out_id, exp_id[c-1]); end
            end
            tick();
            if (exp_id[c] == 1) begin
                t1++;
                if (t1 == 3) begin
                    req_valid[1] = 1'b0;
                end else begin
                    req_data[DW +: DW] = tok1[t1];
                    req_last[1] = (t1 == 2);
                end
            end
        end
        #1;
        checks++; if (out_id !== 2'(exp_id[4])) begin errors++; $display("[TB] FAIL burst_last_id got %0d exp %0d", out_id, exp_id[4]); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = 16'($urandom);
                    req_last[i] = 1'($urandom_range(1));
                end
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            exp_rdy = m_ready();
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rand_ready c%0d got %b exp %b", c, req_ready, exp_rdy); end
            checks++; if (out_valid !== m_full) begin errors++; $display("[TB] FAIL rand_valid c%0d got %b exp %b", c, out_valid, m_full); end
            if (m_full) begin
                checks++; if (out_data !== m_data || out_id !== 2'(m_id)) begin errors++; $display("[TB] FAIL rand_out c%0d got %h/%0d exp %h/%0d", c, out_data, out_id, m_data, m_id); end
            end
            acc = exp_rdy & req_valid;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(1) == 0) begin
                        req_valid[i] = 1'b0;
                    end else begin
                        req_data[i*DW +: DW] = 16'($urandom);
                        req_last[i] = 1'($urandom_range(1));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_lock_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
